serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse-direction companion to the team's one-bit adder datapath. Computes a - b one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. Start/done handshake; operands latched at start; result held until the next operation. Used where ripple area matters more than latency (ALU bring-up, multicycle divide datapath).

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle or in DONE
a  input  WIDTH  minuend, latched on accepted start
b  input  WIDTH  subtrahend, latched on accepted start
busy  output  1  high while operation in progress (RUN)
done  output  1  one-cycle pulse: diff/borrow_out valid from this cycle on
diff  output  WIDTH  a - b modulo 2^WIDTH
borrow_out  output  1  final borrow; 1 iff a < b unsigned
ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

Behaviour:
- Reset: clock and reset are the only timing inputs; reset is synchronous and active-high. On any rising edge with reset=1: state=IDLE; busy=0, done=0, diff=0, borrow_out=0 (ovf=0); internal shift registers, borrow flop, bit counter cleared. Reset has priority over start and aborts any in-flight operation; partial result discarded.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch a, b into operand shift regs, borrow flop=0, counter=0, go RUN. Else stay.
- RUN: each edge uses LSBs ai, bi and borrow bw:
  - d = ai ^ bi ^ bw
  - bw_next = (~ai & bi) | (~(ai ^ bi) & bw)
  - d shifted into result shift reg from MSB side; operand regs shift right 1; counter++.
  - After the WIDTH-th bit edge (counter == WIDTH-1 at that edge): copy result reg to diff, bw_next to borrow_out, go DONE.
- start while in RUN: ignored; latched operands unchanged.
- DONE: done=1 for exactly this one cycle, busy=0. start=1 here is accepted exactly as in IDLE (back-to-back, next state RUN); else go IDLE.
- busy=1 iff state==RUN. done=1 iff state==DONE.
- Latency: start sampled at edge E0 -> busy high E0..EWIDTH -> done high in cycle after edge EWIDTH. WIDTH+1 edges start to done; throughput one op per WIDTH+1 cycles.
- diff/borrow_out change only on the RUN->DONE edge or reset; they hold the previous result throughout a new RUN.
- Input changes on a/b after acceptance have no effect.
- Wrap-around: result is modulo 2^WIDTH; 0 - 1 = all ones, borrow_out=1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN. Defined: port ovf exists; on the RUN->DONE edge ovf = (a_msb != b_msb) & (diff_msb != a_msb), using latched operand MSBs (separately registered at start); held like diff; reset to 0. Undefined: ovf port and its registers absent; all other behaviour identical.

Test Plan:
WIDTH=8; 8'd100 - 8'd37 at E0 -> busy for 9 edges, done pulse one cycle after E8, diff=8'h3F, borrow_out=0.
8'h05 - 8'h0A -> diff=8'hFB, borrow_out=1; 8'h00 - 8'h01 -> diff=8'hFF, borrow_out=1; 8'h00 - 8'h00 -> diff=0, borrow_out=0.
SERIAL_SUB_OVF_EN defined: 8'h80 - 8'h01 -> diff=8'h7F, ovf=1, borrow_out=0; 8'h7F - 8'hFF -> diff=8'h80, ovf=1, borrow_out=1; 8'h10 - 8'h01 -> ovf=0.
Start 8'h20 - 8'h10, then at cycle 3 pulse start with 8'hFF - 8'h00 -> ignored, diff=8'h10.
Reset at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0; no done pulse follows; fresh start 8'h09 - 8'h03 -> diff=8'h06.
Hold start=1 continuously with operands 8'h0A/8'h03 then 8'h03/8'h0A -> done pulses every 9 cycles, diffs 8'h07 then 8'hF9 (borrow 1), no idle cycle between ops.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Optional signed-overflow output guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, a_sh_next;
   logic [WIDTH-1:0] b_sh, b_sh_next;
   logic [WIDTH-1:0] res, res_next;
   logic [WIDTH-1:0] diff_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic             bw, bw_next;
   logic             borrow_out_next;
   logic             bit_d_c;
   logic             bit_bw_c;

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb, a_msb_next;
   logic b_msb, b_msb_next;
   logic ovf_next;
`endif

   // Single full-subtractor cell on the operand LSBs
   assign bit_d_c  = a_sh[0] ^ b_sh[0] ^ bw;
   assign bit_bw_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state and datapath next values
   always_comb begin
      state_next      = state;
      a_sh_next       = a_sh;
      b_sh_next       = b_sh;
      res_next        = res;
      cnt_next        = cnt;
      bw_next         = bw;
      diff_next       = diff;
      borrow_out_next = borrow_out;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_next      = a_msb;
      b_msb_next      = b_msb;
      ovf_next        = ovf;
`endif
      case (state)
         IDLE, DONE: begin
            if (start) begin
               a_sh_next  = a;
               b_sh_next  = b;
               res_next   = '0;
               cnt_next   = '0;
               bw_next    = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_next = a[WIDTH-1];
               b_msb_next = b[WIDTH-1];
`endif
               state_next = RUN;
            end else if (state == DONE) begin
               state_next = IDLE;
            end
         end
         RUN: begin
            a_sh_next = {1'b0, a_sh[WIDTH-1:1]};
            b_sh_next = {1'b0, b_sh[WIDTH-1:1]};
            res_next  = {bit_d_c, res[WIDTH-1:1]};
            bw_next   = bit_bw_c;
            cnt_next  = cnt + CW'(1);
            if (cnt == LAST_BIT) begin
               diff_next       = {bit_d_c, res[WIDTH-1:1]};
               borrow_out_next = bit_bw_c;
`ifdef SERIAL_SUB_OVF_EN
               ovf_next        = (a_msb != b_msb) & (bit_d_c != a_msb);
`endif
               state_next      = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         a_sh       <= '0;
         b_sh       <= '0;
         res        <= '0;
         cnt        <= '0;
         bw         <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         ovf        <= 1'b0;
`endif
      end else begin
         a_sh       <= a_sh_next;
         b_sh       <= b_sh_next;
         res        <= res_next;
         cnt        <= cnt_next;
         bw         <= bw_next;
         diff       <= diff_next;
         borrow_out <= borrow_out_next;
         busy       <= (state_next == RUN);
         done       <= (state_next == DONE);
`ifdef SERIAL_SUB_OVF_EN
         a_msb      <= a_msb_next;
         b_msb      <= b_msb_next;
         ovf        <= ovf_next;
`endif
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   always #5 clock = ~clock;

   // Issues one operation; returns edges after E0 until done, and busy cycles seen
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int edges, output int busy_cnt);
      @(negedge clock);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clock);
      #1;
      start    = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      edges    = 0;
      busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         @(posedge clock);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
      checks++;
      if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int e, bc;
      run_op(8'd100, 8'd37, e, bc);
      checks++;
      if (e !== 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", e); end
      checks++;
      if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      checks++;
      if (diff !== 8'h3F) begin errors++; $display("FAIL basic_diff got=%h exp=3f", diff); end
      checks++;
      if (borrow_out !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", borrow_out); end
      @(posedge clock);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      checks++;
      if (diff !== 8'h3F) begin errors++; $display("FAIL basic_diff_hold got=%h exp=3f", diff); end
   endtask

   task automatic test_borrow;
      logic [W-1:0] va [4] = '{8'h05, 8'h00, 8'h00, 8'hC8};
      logic [W-1:0] vb [4] = '{8'h0A, 8'h01, 8'h00, 8'h64};
      logic [W-1:0] vd [4] = '{8'hFB, 8'hFF, 8'h00, 8'h64};
      logic         vw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int e, bc;
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], e, bc);
         checks++;
         if (diff !== vd[i] || done !== 1'b1) begin
            errors++;
            $display("FAIL borrow_diff[%0d] got=%h done=%b exp=%h", i, diff, done, vd[i]);
         end
         checks++;
         if (borrow_out !== vw[i]) begin
            errors++;
            $display("FAIL borrow_flag[%0d] got=%b exp=%b", i, borrow_out, vw[i]);
         end
      end
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf;
      logic [W-1:0] va [3] = '{8'h80, 8'h7F, 8'h10};
      logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h01};
      logic [W-1:0] vd [3] = '{8'h7F, 8'h80, 8'h0F};
      logic         vw [3] = '{1'b0, 1'b1, 1'b0};
      logic         vo [3] = '{1'b1, 1'b1, 1'b0};
      int e, bc;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], e, bc);
         checks++;
         if (diff !== vd[i] || borrow_out !== vw[i] || ovf !== vo[i]) begin
            errors++;
            $display("FAIL ovf_case[%0d] got diff=%h bo=%b ovf=%b exp diff=%h bo=%b ovf=%b",
                     i, diff, borrow_out, ovf, vd[i], vw[i], vo[i]);
         end
      end
   endtask
`endif

   task automatic test_start_ignored;
      int n;
      @(negedge clock);
      start = 1'b1; a = 8'h20; b = 8'h10;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      start = 1'b1; a = 8'hFF; b = 8'h00;
      @(negedge clock);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (diff !== 8'h10 || borrow_out !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start got diff=%h bo=%b done=%b exp diff=10 bo=0 done=1", diff, borrow_out, done);
      end
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle got busy=%b exp=0", busy); end
   endtask

   task automatic test_reset_abort;
      int e, bc, seen;
      @(negedge clock);
      start = 1'b1; a = 8'h55; b = 8'h11;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL abort_state got busy=%b done=%b diff=%h bo=%b exp 0 0 00 0", busy, done, diff, borrow_out);
      end
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clock);
         #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d active cycles exp=0", seen); end
      run_op(8'h09, 8'h03, e, bc);
      checks++;
      if (diff !== 8'h06 || borrow_out !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL abort_fresh got diff=%h bo=%b done=%b exp 06 0 1", diff, borrow_out, done);
      end
   endtask

   task automatic test_back_to_back;
      int n, held_bad;
      @(negedge clock);
      start = 1'b1; a = 8'h0A; b = 8'h03;
      @(posedge clock);
      #1;
      a = 8'h03; b = 8'h0A;
      n = 0;
      while (!done && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (n !== 8 || diff !== 8'h07 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first got edges=%0d diff=%h bo=%b exp 8 07 0", n, diff, borrow_out);
      end
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_idle got busy=%b done=%b exp 1 0", busy, done);
      end
      n = 1;
      held_bad = 0;
      while (!done && n < 40) begin
         if (diff !== 8'h07) held_bad++;
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (held_bad !== 0) begin errors++; $display("FAIL b2b_diff_held got=%0d changes exp=0", held_bad); end
      checks++;
      if (n !== 9 || diff !== 8'hF9 || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second got period=%0d diff=%h bo=%b exp 9 f9 1", n, diff, borrow_out);
      end
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_stop got busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_borrow();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
